// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the pipeline stages (master) and pipe_ctrl (slave).
// Address width comes from the A_SIZE macro (16 bits when not supplied by the build).
`ifndef A_SIZE
`define A_SIZE 16
`endif

interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic               jmp_req;
  logic [`A_SIZE-1:0] jmp_target;
  logic               load_dep;
  logic               wb_conflict;
  logic               halt_seen;
  logic               resume;
  logic               stall_fetch;
  logic               stall_read;
  logic               flush_read;
  logic               pc_load;
  logic [`A_SIZE-1:0] pc_load_val;
  logic               halted;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output jmp_req, jmp_target, load_dep, wb_conflict, halt_seen, resume,
    input  stall_fetch, stall_read, flush_read, pc_load, pc_load_val, halted, stall_cnt
  );

  modport slave (
    input  jmp_req, jmp_target, load_dep, wb_conflict, halt_seen, resume,
    output stall_fetch, stall_read, flush_read, pc_load, pc_load_val, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump flush, load-use stall, write-back stall, HALT/resume.
// Macro PIPE_CTRL_PERF_EN enables the saturating stall_cnt counter; otherwise stall_cnt is 0.
`ifndef A_SIZE
`define A_SIZE 16
`endif

module pipe_ctrl #(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    FLUSH     = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [3:0]         wait_cnt_r;
  logic [3:0]         wait_next_s;
  logic               stall_fetch_s;
  logic               stall_read_s;
  logic               flush_read_s;
  logic               pc_load_s;
  logic [`A_SIZE-1:0] pc_load_val_s;
  logic               halted_s;

  // State and load-wait counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_next_s;
    end
  end

  // Next-state and output decode; RUN events resolved in priority order
  always_comb begin
    state_next_s  = state_r;
    wait_next_s   = 4'd0;
    stall_fetch_s = 1'b0;
    stall_read_s  = 1'b0;
    flush_read_s  = 1'b0;
    pc_load_s     = 1'b0;
    pc_load_val_s = {`A_SIZE{1'b0}};
    halted_s      = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.jmp_req) begin
          pc_load_s     = 1'b1;
          pc_load_val_s = bus.jmp_target;
          flush_read_s  = 1'b1;
          state_next_s  = FLUSH;
        end else if (bus.load_dep) begin
          stall_fetch_s = 1'b1;
          stall_read_s  = 1'b1;
          // The RUN cycle itself is the first stall cycle, so LOAD_LAT=1 never leaves RUN
          if (LOAD_LAT > 1) begin
            wait_next_s  = 4'(LOAD_LAT - 1);
            state_next_s = LOAD_WAIT;
          end else begin
            wait_next_s  = 4'd0;
            state_next_s = RUN;
          end
        end else if (bus.wb_conflict) begin
          stall_fetch_s = 1'b1;
        end else if (bus.halt_seen) begin
          stall_fetch_s = 1'b1;
          state_next_s  = HALT;
        end else begin
          state_next_s  = RUN;
        end
      end
      LOAD_WAIT: begin
        stall_fetch_s = 1'b1;
        stall_read_s  = 1'b1;
        if (wait_cnt_r <= 4'd1) begin
          wait_next_s  = 4'd0;
          state_next_s = RUN;
        end else begin
          wait_next_s  = wait_cnt_r - 4'd1;
          state_next_s = LOAD_WAIT;
        end
      end
      FLUSH: begin
        flush_read_s = 1'b1;
        state_next_s = RUN;
      end
      HALT: begin
        halted_s      = 1'b1;
        stall_fetch_s = 1'b1;
        if (bus.resume) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HALT;
        end
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  assign bus.stall_fetch = rst ? 1'b0 : stall_fetch_s;
  assign bus.stall_read  = rst ? 1'b0 : stall_read_s;
  assign bus.flush_read  = rst ? 1'b0 : flush_read_s;
  assign bus.pc_load     = rst ? 1'b0 : pc_load_s;
  assign bus.pc_load_val = rst ? {`A_SIZE{1'b0}} : pc_load_val_s;
  assign bus.halted      = rst ? 1'b0 : halted_s;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of stall_fetch cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.stall_fetch && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
